// File: rtl/mem_bus_arb.sv
// rtl/mem_bus_arb.sv - round-robin refill arbiter between I-cache and D-cache on one beat-wise memory bus
//
// Purpose: picks one cache refill request at a time (round-robin), runs a
// BEATS-long read burst on the external bus, assembles the beats into a
// line and hands the line back with a one-cycle data-valid pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_addr, i_rd          I-cache block address and level refill request
//   i_data, i_dv          line returned to the I-cache, one-cycle valid
//   d_addr, d_rd          D-cache block address and level refill request
//   d_data, d_dv          line returned to the D-cache, one-cycle valid
//   m_addr, m_rd          external byte address and level burst request
//   m_data_in, m_dv       external beat data and per-beat valid
//   gnt                   current owner: 00 none, 01 I-cache, 10 D-cache
module mem_bus_arb #(
  parameter int BLK_W  = 58,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BLK_W-1:0]  i_addr,
  input  logic              i_rd,
  output logic [LINE_W-1:0] i_data,
  output logic              i_dv,
  input  logic [BLK_W-1:0]  d_addr,
  input  logic              d_rd,
  output logic [LINE_W-1:0] d_data,
  output logic              d_dv,
  output logic [63:0]       m_addr,
  output logic              m_rd,
  input  logic [BEAT_W-1:0] m_data_in,
  input  logic              m_dv,
  output logic [1:0]        gnt
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                last_gnt_q, last_gnt_d;  // 0 = I-cache, 1 = D-cache
  logic [1:0]          mask_q, mask_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [63:0]         m_addr_q, m_addr_d;
  logic                m_rd_q, m_rd_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   i_data_q, i_data_d;
  logic [LINE_W-1:0]   d_data_q, d_data_d;
  logic                i_dv_q, i_dv_d;
  logic                d_dv_q, d_dv_d;

  logic                req_i, req_d, pick_d;
  logic [LINE_W-1:0]   filled;

  // The port served last is masked for one IDLE cycle so its still-high rd
  // (it drops only in the cycle after dv) cannot trigger a duplicate refill.
  assign req_i  = i_rd & ~mask_q[0];
  assign req_d  = d_rd & ~mask_q[1];
  // D wins when it is the only requester, or when both request and I was served last.
  assign pick_d = req_d & (~req_i | ~last_gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      last_gnt_q <= 1'b0;
      mask_q     <= 2'b00;
      beat_cnt_q <= '0;
      m_addr_q   <= 64'd0;
      m_rd_q     <= 1'b0;
      line_q     <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
      i_dv_q     <= 1'b0;
      d_dv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      mask_q     <= mask_d;
      beat_cnt_q <= beat_cnt_d;
      m_addr_q   <= m_addr_d;
      m_rd_q     <= m_rd_d;
      line_q     <= line_d;
      i_data_q   <= i_data_d;
      d_data_q   <= d_data_d;
      i_dv_q     <= i_dv_d;
      d_dv_q     <= d_dv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    mask_d     = mask_q;
    beat_cnt_d = beat_cnt_q;
    m_addr_d   = m_addr_q;
    m_rd_d     = m_rd_q;
    line_d     = line_q;
    i_data_d   = i_data_q;
    d_data_d   = d_data_q;
    i_dv_d     = 1'b0;
    d_dv_d     = 1'b0;

    // Line buffer with the current beat merged in, so the last beat can be
    // forwarded to the winner in the same edge it is captured.
    filled = line_q;
    filled[beat_cnt_q*BEAT_W +: BEAT_W] = m_data_in;

    unique case (state_q)
      IDLE: begin
        mask_d = 2'b00;
        if (req_i || req_d) begin
          state_d    = FILL;
          m_rd_d     = 1'b1;
          beat_cnt_d = '0;
          if (pick_d) begin
            gnt_d    = 2'b10;
            m_addr_d = {d_addr, {OFF_W{1'b0}}};
          end else begin
            gnt_d    = 2'b01;
            m_addr_d = {i_addr, {OFF_W{1'b0}}};
          end
        end
      end
      FILL: begin
        if (m_dv) begin
          line_d     = filled;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            m_rd_d  = 1'b0;
            state_d = RESP;
            if (gnt_q[1]) begin
              d_data_d = filled;
              d_dv_d   = 1'b1;
            end else begin
              i_data_d = filled;
              i_dv_d   = 1'b1;
            end
          end
        end
      end
      RESP: begin
        last_gnt_d = gnt_q[1];
        mask_d     = gnt_q;
        gnt_d      = 2'b00;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_data = i_data_q;
  assign i_dv   = i_dv_q;
  assign d_data = d_data_q;
  assign d_dv   = d_dv_q;
  assign m_addr = m_addr_q;
  assign m_rd   = m_rd_q;
  assign gnt    = gnt_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb/tb_mem_bus_arb.sv - scoreboard testbench for mem_bus_arb
module tb_mem_bus_arb;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [57:0]   i_addr = '0, d_addr = '0;
  logic          i_rd = 1'b0, d_rd = 1'b0;
  logic [511:0]  i_data, d_data;
  logic          i_dv, d_dv;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic [63:0]   m_data_in = '0;
  logic          m_dv = 1'b0;
  logic [1:0]    gnt;

  int checks = 0;
  int errors = 0;
  int i_dv_cnt = 0;
  int d_dv_cnt = 0;

  typedef struct packed {
    logic         port;   // 0 = I, 1 = D
    logic [511:0] data;
  } exp_t;
  exp_t sb[$];

  mem_bus_arb #(.BLK_W(58), .LINE_W(512), .BEAT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
    .d_addr(d_addr), .d_rd(d_rd), .d_data(d_data), .d_dv(d_dv),
    .m_addr(m_addr), .m_rd(m_rd), .m_data_in(m_data_in), .m_dv(m_dv),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [63:0] base);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_line(input logic port, input logic [63:0] base);
    exp_t e;
    e.port = port;
    e.data = line_of(base);
    sb.push_back(e);
  endtask

  task automatic mon(input logic port, input logic [511:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_dv: got dv on port %0d, expected none", port);
    end else begin
      e = sb.pop_front();
      chk("sb_port", {511'd0, port}, {511'd0, e.port});
      chk("sb_data", data, e.data);
    end
  endtask

  // Monitor: pops the scoreboard whenever either port presents a line.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_dv) begin
        i_dv_cnt++;
        mon(1'b0, i_data);
      end
      if (d_dv) begin
        d_dv_cnt++;
        mon(1'b1, d_data);
      end
    end
  end

  // Memory side: drives beats base+k on each high bit of pat; gap cycles carry
  // junk data that must not be captured. Returns in the IDLE cycle after RESP.
  task automatic serve(input logic [63:0] base, input logic [31:0] pat, input int plen);
    int held = 0;
    int dvs = 0;
    int k = 0;
    for (int p = 0; p < plen; p++) begin
      m_dv = pat[p];
      m_data_in = pat[p] ? base + 64'(k) : 64'hBAD0_BAD0_BAD0_BAD0;
      if (pat[p]) k++;
      if (m_rd) held++;
      if (i_dv || d_dv) dvs++;
      tick();
    end
    m_dv = 1'b0;
    m_data_in = '0;
    chk("m_rd_held", 512'(held), 512'(plen));
    chk("no_dv_in_burst", 512'(dvs), 512'd0);
    chk("m_rd_drop", {511'd0, m_rd}, 512'd0);
    chk("dv_latency", {511'd0, i_dv | d_dv}, 512'd1);
    tick();
    chk("dv_one_cycle", {511'd0, i_dv | d_dv}, 512'd0);
  endtask

  task automatic chk_grant(input logic [1:0] g, input logic [63:0] a);
    chk("gnt", {510'd0, gnt}, {510'd0, g});
    chk("m_addr", {448'd0, m_addr}, {448'd0, a});
    chk("m_rd_on", {511'd0, m_rd}, 512'd1);
  endtask

  initial begin : stim
    int dcnt0;
    int icnt0;
    logic [511:0] isave, dsave;

    // Reset state
    tick(); tick();
    chk("rst_m_rd", {511'd0, m_rd}, 512'd0);
    chk("rst_m_addr", {448'd0, m_addr}, 512'd0);
    chk("rst_gnt", {510'd0, gnt}, 512'd0);
    chk("rst_dv", {510'd0, i_dv, d_dv}, 512'd0);
    chk("rst_i_data", i_data, 512'd0);
    chk("rst_d_data", d_data, 512'd0);
    rst_n = 1'b1;
    tick();

    // I-only, continuous beats 0x10..0x17
    i_addr = 58'h1; i_rd = 1'b1;
    tick();
    chk_grant(2'b01, 64'h40);
    expect_line(1'b0, 64'h10);
    serve(64'h10, 32'hFF, 8);
    i_rd = 1'b0;
    chk("i_data_lo", {448'd0, i_data[63:0]}, 512'h10);
    chk("i_data_hi", {448'd0, i_data[511:448]}, 512'h17);
    tick();
    chk("a_d_dv_cnt", 512'(d_dv_cnt), 512'd0);

    // Simultaneous requests straight out of reset: D first, then I
    rst_n = 1'b0;
    tick();
    i_addr = 58'h2; d_addr = 58'h3; i_rd = 1'b1; d_rd = 1'b1; rst_n = 1'b1;
    tick();
    chk_grant(2'b10, 64'hC0);
    expect_line(1'b1, 64'h100);
    serve(64'h100, 32'hFF, 8);
    tick();                       // d_rd stale here; I must win
    d_rd = 1'b0;
    chk_grant(2'b01, 64'h80);
    expect_line(1'b0, 64'h200);
    serve(64'h200, 32'hFF, 8);
    i_rd = 1'b0;
    tick();
    i_addr = 58'h4; d_addr = 58'h5; i_rd = 1'b1; d_rd = 1'b1;
    tick();
    chk_grant(2'b10, 64'h140);
    expect_line(1'b1, 64'h300);
    serve(64'h300, 32'hFF, 8);
    d_rd = 1'b0;
    tick();
    chk_grant(2'b01, 64'h100);
    expect_line(1'b0, 64'h400);
    serve(64'h400, 32'hFF, 8);
    i_rd = 1'b0;
    tick();

    // Stale d_rd one cycle after d_dv must not re-grant D
    dcnt0 = d_dv_cnt;
    d_addr = 58'h6; d_rd = 1'b1;
    tick();
    chk_grant(2'b10, 64'h180);
    expect_line(1'b1, 64'h500);
    serve(64'h500, 32'hFF, 8);
    tick();
    d_rd = 1'b0;
    chk("stale_gnt", {510'd0, gnt}, 512'd0);
    chk("stale_m_rd", {511'd0, m_rd}, 512'd0);
    tick(); tick();
    chk("stale_d_dv_cnt", 512'(d_dv_cnt - dcnt0), 512'd1);

    // Beat gaps: 1,0,0,1,1,0,1,1,1,1,1
    i_addr = 58'h7; i_rd = 1'b1;
    tick();
    chk_grant(2'b01, 64'h1C0);
    expect_line(1'b0, 64'h600);
    serve(64'h600, 32'b111_1101_1001, 11);
    i_rd = 1'b0;
    tick();

    // Reset after 3 beats abandons the burst; D is re-served afterwards
    d_addr = 58'h8; d_rd = 1'b1;
    tick();
    chk_grant(2'b10, 64'h200);
    for (int k = 0; k < 3; k++) begin
      m_dv = 1'b1; m_data_in = 64'h700 + 64'(k);
      tick();
    end
    m_dv = 1'b0; m_data_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_rd", {511'd0, m_rd}, 512'd0);
    chk("mid_rst_gnt", {510'd0, gnt}, 512'd0);
    chk("mid_rst_m_addr", {448'd0, m_addr}, 512'd0);
    chk("mid_rst_data", i_data | d_data, 512'd0);
    chk("mid_rst_dv", {510'd0, i_dv, d_dv}, 512'd0);
    tick();
    rst_n = 1'b1;
    dcnt0 = d_dv_cnt;
    tick();
    chk_grant(2'b10, 64'h200);
    expect_line(1'b1, 64'h800);
    serve(64'h800, 32'hFF, 8);
    d_rd = 1'b0;
    tick(); tick();
    chk("rst_d_dv_cnt", 512'(d_dv_cnt - dcnt0), 512'd1);

    // Spurious m_dv in IDLE
    isave = i_data; dsave = d_data;
    icnt0 = i_dv_cnt; dcnt0 = d_dv_cnt;
    for (int k = 0; k < 3; k++) begin
      m_dv = 1'b1; m_data_in = 64'hDEAD_0000 + 64'(k);
      tick();
    end
    m_dv = 1'b0; m_data_in = '0;
    chk("spur_gnt", {510'd0, gnt}, 512'd0);
    chk("spur_m_rd", {511'd0, m_rd}, 512'd0);
    chk("spur_i_data", i_data, isave);
    chk("spur_d_data", d_data, dsave);
    chk("spur_dv_cnt", 512'((i_dv_cnt - icnt0) + (d_dv_cnt - dcnt0)), 512'd0);
    i_addr = 58'h9; i_rd = 1'b1;
    tick();
    chk_grant(2'b01, 64'h240);
    expect_line(1'b0, 64'h900);
    serve(64'h900, 32'hFF, 8);
    i_rd = 1'b0;
    tick(); tick();

    chk("sb_drained", 512'(sb.size()), 512'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
